// File: rtl/int_add_arbiter_if.sv
// Bus bundle between N requesters, the arbiter and the shared int_add adder.
// slave = arbiter view, master = requesters plus adder view.
interface int_add_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_accept;
  logic [31:0]     req_c;
  logic            req_err;
  logic [N-1:0]    grant;
  logic            add_ready;
  logic            add_accept;
  logic            add_valid;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_c;

  modport slave (
    input  req_ready, req_a, req_b,
    input  req_accept, add_valid, add_c,
    output req_valid, req_c, req_err,
    output grant, add_ready, add_accept,
    output add_a, add_b
  );

  modport master (
    output req_ready, req_a, req_b,
    output req_accept, add_valid, add_c,
    input  req_valid, req_c, req_err,
    input  grant, add_ready, add_accept,
    input  add_a, add_b
  );
endinterface

// File: rtl/int_add_arbiter.sv
// Round-robin arbiter sharing one int_add adder among N requesters.
// Define INT_ADD_ARB_TIMEOUT_EN to build the WAIT watchdog.
module int_add_arbiter #(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  int_add_arbiter_if.slave bus
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LW-1:0] last;
  logic [LW-1:0] win;
  logic [LW-1:0] cand;
  logic          win_hit;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  valid_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   c_q;
  logic          err_q;
  logic          acc_hit;
  logic          timeout;
  logic          add_ready_c;
  logic          add_accept_c;

  // Search upward from last+1 with wrap, so last itself is checked last.
  always_comb begin
    win     = '0;
    win_hit = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = LW'((int'(last) + k) % N);
      if (!win_hit && bus.req_ready[cand]) begin
        win_hit = 1'b1;
        win     = cand;
      end
    end
  end

  assign win_oh  = N'(1) << win;
  assign acc_hit = |(bus.req_accept & grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_hit) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.add_valid || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (acc_hit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    add_ready_c  = 1'b0;
    add_accept_c = 1'b0;
    unique case (1'b1)
      (state == ISSUE): begin
        add_ready_c = 1'b1;
      end
      (state == WAIT): begin
        add_accept_c = bus.add_valid;
      end
      default: begin
        add_ready_c  = 1'b0;
        add_accept_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      grant_q <= '0;
      valid_q <= '0;
      last    <= LW'(N - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (win_hit) begin
            a_q     <= bus.req_a[int'(win)*32 +: 32];
            b_q     <= bus.req_b[int'(win)*32 +: 32];
            grant_q <= win_oh;
            last    <= win;
          end
        end
        WAIT: begin
          if (bus.add_valid) begin
            c_q     <= bus.add_c;
            valid_q <= grant_q;
          end else if (timeout) begin
            c_q     <= '0;
            valid_q <= grant_q;
          end
        end
        RESP: begin
          if (acc_hit) begin
            valid_q <= '0;
            grant_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INT_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt;

  // Zero outside WAIT, so each WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == WAIT) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign timeout = (state == WAIT) && !bus.add_valid &&
                   (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == WAIT) begin
      if (bus.add_valid) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
  assign err_q              = 1'b0;
`endif

  assign bus.grant      = grant_q;
  assign bus.req_valid  = valid_q;
  assign bus.req_c      = c_q;
  assign bus.req_err    = err_q;
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.add_ready  = add_ready_c;
  assign bus.add_accept = add_accept_c;

endmodule

// File: tb/tb_int_add_arbiter.sv
// Directed bench for int_add_arbiter with a two-stage int_add stub.
// Timeout checks run when INT_ADD_ARB_TIMEOUT_EN is defined.
module tb_int_add_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int_add_arbiter_if #(.N(N)) bus ();

  int_add_arbiter #(
    .N(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Adder stub: start sampled at E+1, valid visible after E+3.
  logic        s1, s2, s_vld, s_acc;
  logic [31:0] s_sum;
  logic [1:0]  s_hold;
  logic        stub_mute  = 1'b0;
  logic        stub_stale = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_vld  <= 1'b0;
      s_acc  <= 1'b0;
      s_sum  <= '0;
      s_hold <= '0;
    end else begin
      s1 <= bus.add_ready & ~stub_mute;
      s2 <= s1;
      if (s2) begin
        s_vld  <= 1'b1;
        s_sum  <= bus.add_a + bus.add_b;
        s_hold <= 2'd3;
        s_acc  <= 1'b0;
      end else if (s_vld && (bus.add_accept || s_acc)) begin
        if (stub_stale && s_hold != 0) begin
          s_hold <= s_hold - 1'b1;
          s_acc  <= 1'b1;
        end else begin
          s_vld <= 1'b0;
          s_acc <= 1'b0;
        end
      end
    end
  end

  assign bus.add_valid = s_vld;
  assign bus.add_c     = s_sum;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input logic [31:0] a,
                     input logic [31:0] b);
    bus.req_a[idx*32 +: 32] = a;
    bus.req_b[idx*32 +: 32] = b;
  endtask

  task automatic do_op(input string nm, input logic [3:0] rdy,
                       input logic [3:0] eg, input logic [31:0] ec,
                       input int bp);
    logic [3:0] wrong;
    bus.req_ready = rdy;
    tick();
    chk({nm, "_grant"}, 32'(bus.grant), 32'(eg));
    chk({nm, "_issue"}, 32'(bus.add_ready), 32'd1);
    bus.req_ready = '0;
    tick();
    chk({nm, "_issue_once"}, 32'(bus.add_ready), 32'd0);
    tick();
    tick();
    chk({nm, "_early"}, 32'(bus.req_valid), 32'd0);
    tick();
    chk({nm, "_valid"}, 32'(bus.req_valid), 32'(eg));
    chk({nm, "_sum"}, bus.req_c, ec);
    chk({nm, "_err"}, 32'(bus.req_err), 32'd0);
    wrong = ~eg;
    bus.req_accept = wrong;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({nm, "_bp_valid"}, 32'(bus.req_valid), 32'(eg));
      chk({nm, "_bp_sum"}, bus.req_c, ec);
      chk({nm, "_bp_issue"}, 32'(bus.add_ready), 32'd0);
    end
    bus.req_accept = eg;
    tick();
    chk({nm, "_done_valid"}, 32'(bus.req_valid), 32'd0);
    chk({nm, "_done_grant"}, 32'(bus.grant), 32'd0);
    bus.req_accept = '0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  g;
  } vec_t;

  vec_t vt[4];

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa[4];
    logic [31:0] fb[4];
    logic [3:0]  fg;
    logic        found;
    logic        acc_seen;
    int          gi;
    int          last_issue;

    vt[0] = '{2, 32'd5,          32'd7,          32'd12,         4'b0100};
    vt[1] = '{1, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  4'b0010};
    vt[2] = '{3, 32'h8000_0000,  32'h8000_0000,  32'h0,          4'b1000};
    vt[3] = '{0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  4'b0001};

    bus.req_ready  = '0;
    bus.req_accept = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;

    tick();
    tick();
    chk("rst_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_c", bus.req_c, 32'd0);
    chk("rst_err", 32'(bus.req_err), 32'd0);
    chk("rst_ready", 32'(bus.add_ready), 32'd0);
    chk("rst_accept", 32'(bus.add_accept), 32'd0);
    chk("rst_a", bus.add_a, 32'd0);
    chk("rst_b", bus.add_b, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      put(vt[v].idx, vt[v].a, vt[v].b);
      do_op($sformatf("vec%0d", v), 4'(1 << vt[v].idx),
            vt[v].g, vt[v].c, 0);
    end

    put(1, 32'hDEAD_0000, 32'h0000_BEEF);
    do_op("bp", 4'b0010, 4'b0010, 32'hDEAD_BEEF, 10);

    stub_stale = 1'b1;
    put(1, 32'hFFFF_FFFF, 32'd2);
    do_op("stale", 4'b0010, 4'b0010, 32'h1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale_valid", 32'(bus.req_valid), 32'd0);
      chk("stale_issue", 32'(bus.add_ready), 32'd0);
      chk("stale_grant", 32'(bus.grant), 32'd0);
    end
    tick();
    tick();
    stub_stale = 1'b0;

    put(3, 32'd100, 32'd200);
    bus.req_ready = 4'b1000;
    tick();
    chk("rstw_grant", 32'(bus.grant), 32'b1000);
    bus.req_ready = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_valid", 32'(bus.req_valid), 32'd0);
    chk("rstw_grant0", 32'(bus.grant), 32'd0);
    chk("rstw_c", bus.req_c, 32'd0);
    chk("rstw_err", 32'(bus.req_err), 32'd0);
    chk("rstw_ready", 32'(bus.add_ready), 32'd0);
    chk("rstw_accept", 32'(bus.add_accept), 32'd0);
    chk("rstw_a", bus.add_a, 32'd0);
    chk("rstw_b", bus.add_b, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstw_no_result", 32'(bus.req_valid), 32'd0);
    end
    put(0, 32'd40, 32'd2);
    put(2, 32'd9, 32'd9);
    do_op("rstw_first", 4'b0101, 4'b0001, 32'd42, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fa[i] = 32'(i * 100 + 1);
      fb[i] = 32'(i * 1000 + 3);
      put(i, fa[i], fb[i]);
    end
    bus.req_ready  = 4'hF;
    bus.req_accept = 4'hF;
    last_issue = 0;
    for (int k = 0; k < 5; k++) begin
      gi = k % 4;
      fg = 4'(1 << gi);
      found = 1'b0;
      for (int t = 0; t < 12 && !found; t++) begin
        tick();
        if (bus.add_ready) found = 1'b1;
      end
      chk("fair_issue", 32'(found), 32'd1);
      chk("fair_grant", 32'(bus.grant), 32'(fg));
      if (k > 0) chk("fair_period", 32'(cyc - last_issue), 32'd6);
      last_issue = cyc;
      found = 1'b0;
      for (int t = 0; t < 12 && !found; t++) begin
        tick();
        if (bus.req_valid != 0) found = 1'b1;
      end
      chk("fair_resp", 32'(found), 32'd1);
      chk("fair_valid", 32'(bus.req_valid), 32'(fg));
      chk("fair_sum", bus.req_c, fa[gi] + fb[gi]);
      if (k == 4) bus.req_ready = '0;
    end
    tick();
    bus.req_accept = '0;
    chk("fair_idle", 32'(bus.grant), 32'd0);

`ifdef INT_ADD_ARB_TIMEOUT_EN
    stub_mute = 1'b1;
    acc_seen  = 1'b0;
    put(1, 32'd3, 32'd4);
    bus.req_ready = 4'b0010;
    tick();
    chk("to_grant", 32'(bus.grant), 32'b0010);
    bus.req_ready = '0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.add_accept) acc_seen = 1'b1;
    end
    chk("to_early", 32'(bus.req_valid), 32'd0);
    tick();
    chk("to_valid", 32'(bus.req_valid), 32'b0010);
    chk("to_err", 32'(bus.req_err), 32'd1);
    chk("to_c", bus.req_c, 32'd0);
    chk("to_no_accept", 32'(acc_seen), 32'd0);
    bus.req_accept = 4'b0010;
    tick();
    bus.req_accept = '0;
    chk("to_done", 32'(bus.req_valid), 32'd0);
    stub_mute = 1'b0;
    tick();
    tick();
    put(2, 32'd1, 32'd1);
    do_op("to_after", 4'b0100, 4'b0100, 32'd2, 0);
`else
    acc_seen = 1'b0;
    chk("no_to_err", 32'(bus.req_err), 32'(acc_seen));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
